coa_inv: RTL and testbench
==========================

# coa_inv

Sequential inverse of the COA multiply-accumulate datapath. It takes a 10-bit product-plus-offset word D and a 5-bit factor B, and recovers the 5-bit quotient A and 5-bit remainder C such that D = A*B + C with C < B. It sits on the receive side of the COA link and reuses the same valid_in/valid_out handshake and transistor-count reporting. The implementation is a 5-iteration restoring divider with a fixed latency.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-high reset; rst_n=1 clears all state immediately.
- D  input  10  dividend (COA output word).
- B  input  5  divisor (COA factor).
- valid_in  input  1  D/B qualify; sampled only in IDLE or DONE.
- A  output  5  quotient; registered.
- C  output  5  remainder; registered.
- err  output  1  result invalid: B==0 or quotient overflow; registered.
- valid_out  output  1  one-cycle pulse marking A/C/err as new.
- COA_num  output  51  constant transistor tally of this implementation; never changes after reset.

## Operation
- States: IDLE, CALC, DONE.
- IDLE or DONE, valid_in=1 at edge E0: latch D, B, err_pend = (B==0) || (D[9:5] >= B); R <= D[9:5]; shift reg S <= D[4:0]; cnt <= 0; go to CALC.
- IDLE or DONE, valid_in=0: DONE goes to IDLE and IDLE stays IDLE. A/C/err hold.
- CALC, each edge (E1..E5):
  - T = {R, S[4]} (6 bits);
  - if T >= {1'b0,B}: R <= T-B, q bit = 1; else R <= T[4:0], q bit = 0;
  - q shifts in LSB-last, S shifts left, cnt++.
- CALC at E5 (cnt==4 before the edge): A <= err_pend ? 0 : q; C <= err_pend ? 0 : R; err <= err_pend; valid_out <= 1; go to DONE.
- valid_in in CALC is ignored with no queuing. Upstream holds off or the data is lost.
- Arithmetic: D[9:5] < B guarantees R < B at every step, so T fits in 6 bits and A fits in 5. The error case still runs all 5 iterations for fixed latency, and the result is discarded.
- Reset at any time: state IDLE; A=0, C=0, err=0, valid_out=0, and internal registers cleared. A pending operation is aborted with no valid_out pulse.

## Timing
- Reset values: A=0, C=0, err=0, valid_out=0.
- Latency: accept edge E0, result and valid_out=1 visible after E5, valid_out back to 0 after E6.
- valid_out is high exactly one cycle per accepted request. It is never high without a preceding accept.
- Earliest next accept is E5 + 1 edge (E6, in DONE), so peak throughput is one result per 6 cycles.
- A/C/err are stable from E5 until the next result edge or reset.
- COA_num is combinationally constant.

## Test plan
- D=123, B=10, valid_in one cycle -> after E5: A=12, C=3, err=0, valid_out high exactly one cycle.
- D=989, B=31 (max quotient) -> A=31, C=28, err=0. D=1023, B=31 is overflow (D[9:5]=31 >= 31) -> err=1, A=0, C=0.
- B=0, D=5 -> err=1, A=0, C=0 at E5, with latency identical to a normal op.
- Overflow D=640, B=20 -> err=1, A=0, C=0. Then D=639, B=20 -> A=31, C=19, err=0.
- D=100, B=7 accepted at E0; valid_in with D=50, B=3 at E3 ignored; same D=50, B=3 presented at E6 accepted -> A=14, C=2 after E5 and A=16, C=2 after E11, with exactly two valid_out pulses.
- Accept D=200, B=9; assert rst_n at E3 for one cycle -> A=C=err=valid_out=0 immediately and no valid_out pulse. Then D=200, B=9 -> A=22, C=2 with normal latency.

Source files
------------

// File: rtl/coa_inv.sv
// coa_inv: sequential inverse of the COA multiply-accumulate datapath.
// Recovers quotient A and remainder C from D = A*B + C (C < B) with a
// 5-iteration restoring divider. Latency is fixed: accept on E0, result on E5.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active HIGH despite the name
//   D[9:0]     dividend (COA output word)
//   B[4:0]     divisor (COA factor)
//   valid_in   D/B qualifier, sampled only in IDLE or DONE
//   A[4:0]     registered quotient
//   C[4:0]     registered remainder
//   err        registered: B==0 or quotient overflow
//   valid_out  one-cycle pulse marking A/C/err as new
//   COA_num    constant transistor tally of this implementation
module coa_inv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  D,
    input  logic [4:0]  B,
    input  logic        valid_in,
    output logic [4:0]  A,
    output logic [4:0]  C,
    output logic        err,
    output logic        valid_out,
    output logic [50:0] COA_num
);

    localparam logic [50:0] COA_TALLY = 51'd4626;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  b_r;       // latched divisor
    logic [4:0]  r_r;       // partial remainder
    logic [4:0]  s_r;       // low dividend bits, consumed MSB first
    logic [4:0]  q_r;       // quotient bits collected so far
    logic [2:0]  cnt;
    logic        err_pend;

    logic [5:0]  t;
    logic        ge;
    logic [4:0]  r_sub;
    logic [4:0]  r_nxt;
    logic [4:0]  q_nxt;
    logic        accept;

    assign COA_num = COA_TALLY;

    // One restoring step. Low 5 bits of t-b are exact whenever t >= b and
    // R < B holds; in the error case the result is discarded anyway.
    always_comb begin
        t      = {r_r, s_r[4]};
        ge     = (t >= {1'b0, b_r});
        r_sub  = t[4:0] - b_r;
        r_nxt  = ge ? r_sub : t[4:0];
        q_nxt  = {q_r[3:0], ge};
        accept = (state != CALC) && valid_in;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_in) state_nxt = CALC;
            CALC:    if (cnt == 3'd4) state_nxt = DONE;
            DONE:    state_nxt = valid_in ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            b_r       <= '0;
            r_r       <= '0;
            s_r       <= '0;
            q_r       <= '0;
            cnt       <= '0;
            err_pend  <= 1'b0;
            A         <= '0;
            C         <= '0;
            err       <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (accept) begin
                b_r      <= B;
                // D[9:5] >= B would need a 6-bit quotient
                err_pend <= (B == 5'd0) || (D[9:5] >= B);
                r_r      <= D[9:5];
                s_r      <= D[4:0];
                q_r      <= '0;
                cnt      <= '0;
            end else if (state == CALC) begin
                r_r <= r_nxt;
                s_r <= {s_r[3:0], 1'b0};
                q_r <= q_nxt;
                cnt <= cnt + 3'd1;
                if (cnt == 3'd4) begin
                    A         <= err_pend ? 5'd0 : q_nxt;
                    C         <= err_pend ? 5'd0 : r_nxt;
                    err       <= err_pend;
                    valid_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_coa_inv.sv
module tb_coa_inv;

    logic        clk;
    logic        rst_n;
    logic [9:0]  D;
    logic [4:0]  B;
    logic        valid_in;
    logic [4:0]  A;
    logic [4:0]  C;
    logic        err;
    logic        valid_out;
    logic [50:0] COA_num;

    coa_inv dut (
        .clk(clk), .rst_n(rst_n), .D(D), .B(B), .valid_in(valid_in),
        .A(A), .C(C), .err(err), .valid_out(valid_out), .COA_num(COA_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] d;
        logic [4:0] b;
        logic [4:0] a;
        logic [4:0] c;
        logic       e;
    } vec_t;

    typedef struct {
        logic [4:0] a;
        logic [4:0] c;
        logic       e;
        int         e0;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   pulses  = 0;
    int   accepts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every valid_out pulse must match the oldest pending accept,
    // including exactly 5 edges of latency from its accept edge.
    always @(negedge clk) begin
        if (!rst_n && valid_out === 1'b1) begin
            exp_t x;
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid_out: got pulse at cycle %0d expected none", cyc);
            end else begin
                x = sb.pop_front();
                chk("A", int'(A), int'(x.a));
                chk("C", int'(C), int'(x.c));
                chk("err", int'(err), int'(x.e));
                chk("latency", cyc - x.e0, 5);
            end
        end
    end

    // Drive one request on the current negedge so the next posedge samples it.
    task automatic present(input logic [9:0] d, input logic [4:0] b, input bit expect_it,
                           input logic [4:0] ea, input logic [4:0] ec, input logic ee);
        exp_t x;
        D = d;
        B = b;
        valid_in = 1'b1;
        if (expect_it) begin
            x.a = ea; x.c = ec; x.e = ee; x.e0 = cyc + 1;
            sb.push_back(x);
            accepts++;
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic drive(input logic [9:0] d, input logic [4:0] b, input bit expect_it,
                         input logic [4:0] ea, input logic [4:0] ec, input logic ee);
        @(negedge clk);
        present(d, b, expect_it, ea, ec, ee);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{d:10'd123,  b:5'd10, a:5'd12, c:5'd3,  e:1'b0};
        vecs[1] = '{d:10'd989,  b:5'd31, a:5'd31, c:5'd28, e:1'b0};
        vecs[2] = '{d:10'd1023, b:5'd31, a:5'd0,  c:5'd0,  e:1'b1};
        vecs[3] = '{d:10'd5,    b:5'd0,  a:5'd0,  c:5'd0,  e:1'b1};
        vecs[4] = '{d:10'd640,  b:5'd20, a:5'd0,  c:5'd0,  e:1'b1};
        vecs[5] = '{d:10'd639,  b:5'd20, a:5'd31, c:5'd19, e:1'b0};
        vecs[6] = '{d:10'd0,    b:5'd1,  a:5'd0,  c:5'd0,  e:1'b0};
        vecs[7] = '{d:10'd31,   b:5'd1,  a:5'd31, c:5'd0,  e:1'b0};
        vecs[8] = '{d:10'd500,  b:5'd17, a:5'd29, c:5'd7,  e:1'b0};
        vecs[9] = '{d:10'd310,  b:5'd10, a:5'd31, c:5'd0,  e:1'b0};

        rst_n = 1'b1;
        D = '0;
        B = '0;
        valid_in = 1'b0;
        idle(3);
        chk("rst_A", int'(A), 0);
        chk("rst_C", int'(C), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        rst_n = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].d, vecs[i].b, 1'b1, vecs[i].a, vecs[i].c, vecs[i].e);
            idle(5);   // next request lands on E6, the earliest accept
        end

        for (int i = 0; i < 20; i++) begin
            logic [9:0] d;
            logic [4:0] b;
            d = 10'($urandom_range(0, 1023));
            b = 5'($urandom_range(0, 31));
            if (b == 5'd0 || d[9:5] >= b)
                drive(d, b, 1'b1, 5'd0, 5'd0, 1'b1);
            else
                drive(d, b, 1'b1, 5'(d / b), 5'(d % b), 1'b0);
            idle(5 + (i % 3));
        end

        // Request during CALC is dropped; the same request at E6 is taken.
        drive(10'd100, 5'd7, 1'b1, 5'd14, 5'd2, 1'b0);
        idle(2);
        present(10'd50, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0);
        idle(2);
        present(10'd50, 5'd3, 1'b1, 5'd16, 5'd2, 1'b0);
        idle(6);

        // Reset mid-operation aborts it without a pulse.
        drive(10'd200, 5'd9, 1'b0, 5'd0, 5'd0, 1'b0);
        idle(2);
        rst_n = 1'b1;
        #1;
        chk("abort_A", int'(A), 0);
        chk("abort_C", int'(C), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_valid_out", int'(valid_out), 0);
        @(negedge clk);
        rst_n = 1'b0;
        idle(6);
        drive(10'd200, 5'd9, 1'b1, 5'd22, 5'd2, 1'b0);
        idle(8);

        chk("sb_drained", sb.size(), 0);
        chk("pulse_count", pulses, accepts);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
